uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer and launch controller directly upstream of the UART transmitter. It accepts bytes from the application side through a write strobe and stores them in a circular FIFO. It issues one single-cycle start pulse per byte to the transmitter and uses the transmitter's busy/ready status to pace frames back to back.

## Interface
- `FRAME_BITS`, default 8: data width per byte; must match the transmitter's `FRAME_BITS`.
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `BUSY_TIMEOUT`, default 4: cycles to wait in WAIT_BUSY for the transmitter to go busy; ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `wr_en` in 1: write strobe; pushes `wr_data` when not full.
- `wr_data` in FRAME_BITS: byte to enqueue.
- `full` out 1: FIFO holds DEPTH entries.
- `empty` out 1: FIFO holds 0 entries.
- `level` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `tx_start` out 1: one-cycle launch pulse to the transmitter's `start`.
- `tx_data` out FRAME_BITS: byte to the transmitter's `tx_input`.
- `tx_status` in 1: transmitter status; high = busy, low = ready.
- `overflow` out 1: sticky dropped-write flag; see Configuration.

## Operation
- Storage:
  - DEPTH×FRAME_BITS array.
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH)+1 bits wide; each wraps modulo 2·DEPTH.
  - `full` when the MSBs differ and the low bits are equal; `empty` when the pointers are equal.
- Push: on `wr_en && !full`, write `mem[wr_ptr]` and increment `wr_ptr`. When `wr_en && full`, the write is dropped; `full` is evaluated on the pre-edge state, even if a pop happens in the same cycle.
- Pop: happens only in the IDLE launch cycle. If a push and a pop occur in the same cycle, `level` is unchanged.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if `!empty && !tx_status`, register `tx_data <= mem[rd_ptr]` and `tx_start <= 1`, increment `rd_ptr`, and go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: `tx_start` is high for this cycle only (`tx_start <= 0`). Clear the timeout counter and go to WAIT_BUSY.
  - WAIT_BUSY: when `tx_status` is high, go to WAIT_DONE. Otherwise increment the counter; at BUSY_TIMEOUT−1, go to IDLE. In that case the byte is lost and is not re-queued.
  - WAIT_DONE: when `tx_status` is low (the transmitter's one-cycle ready pulse or its idle state), go to IDLE.
- `tx_data` changes only in the IDLE launch cycle. It is therefore stable for the whole frame, including the transmitter's latch edge one cycle after it accepts start.
- Reset (`reset_n` low at an edge), including mid-frame:
  - Pointers are cleared, the FSM returns to IDLE, and `tx_start` is forced to 0. Stored bytes are discarded.
  - The transmitter is not reset by this block. The launch check on `tx_status` keeps the next byte from being launched until the transmitter is ready.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0, `full`=0, `empty`=1, `level`=0, `overflow`=0.
- All outputs are registered or decoded from registers only; there is no combinational path from inputs to outputs.
- Write accepted at edge N:
  - `empty` falls and `level` increments after edge N.
  - `tx_start` is high during cycle N+1..N+2 (registered at edge N+1), provided the transmitter is idle.
- `tx_status` is expected high in the cycle after the `tx_start` pulse.
- Back to back: `tx_status` is low at edge M in WAIT_DONE → IDLE. The next `tx_start` is registered at edge M+1 if `tx_status` is still low.
- Maximum throughput is one byte per frame. The gap between frames is 2–3 cycles of idle line beyond the transmitter's own stop handling.

## Configuration
- `UART_TX_FIFO_OVF_EN`:
  - Defined: `overflow` is set on any `wr_en && full` edge and is cleared only by reset.
  - Undefined: the overflow logic is not compiled and `overflow` is tied to 0. Dropped writes are silent.

## Test plan
- Reset with `reset_n`=0 for 2 cycles → `empty`=1, `level`=0, `tx_start`=0, `tx_data`=0, `overflow`=0.
- Write 0xA5 with the transmitter model idle → `tx_start` is a one-cycle pulse 1 cycle after the write edge, `tx_data`=0xA5 is held until the next launch, and `level` goes 1→0.
- Write 0x01, 0x02, 0x03 back to back with a model that is busy 160 cycles per frame → exactly three `tx_start` pulses, each following a `tx_status` falling edge, carrying 0x01, 0x02, 0x03 in order.
- Fill 16 entries with `tx_status` held high, then issue a 17th write of 0xFF → `full`=1 and `level`=16. With the macro, `overflow`=1; without it, `overflow`=0. Byte 0xFF is never transmitted.
- Hold `tx_status` low after a `tx_start` → after 4 cycles in WAIT_BUSY, return to IDLE and launch the next queued byte; the lost byte is not re-sent.
- Assert reset in WAIT_DONE with 5 bytes queued → after the edge `level`=0 and the FSM is in IDLE. No further `tx_start` occurs until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte buffer and launch controller sitting directly in front of a UART
// transmitter. Application bytes are pushed into a circular FIFO. One byte at
// a time is handed to the transmitter with a single-cycle start pulse. The
// transmitter's busy/ready status paces the frames back to back.
//
// Optional feature macro: UART_TX_FIFO_OVF_EN
//   defined   : `overflow` is a sticky flag, set by any write into a full
//               FIFO and cleared only by reset.
//   undefined : `overflow` is tied to 0 and writes into a full FIFO are
//               dropped silently.
//
// Parameters
//   FRAME_BITS   : bits per byte; must match the transmitter's frame width.
//   DEPTH        : FIFO entries; must be a power of two and at least 2.
//   BUSY_TIMEOUT : cycles allowed for the transmitter to report busy after a
//                  launch; must be at least 2.
//
// Ports
//   clk       in  : single clock, rising edge.
//   reset_n   in  : synchronous, active-low reset.
//   wr_en     in  : write strobe; pushes wr_data when the FIFO is not full.
//   wr_data   in  : byte to enqueue.
//   full      out : FIFO holds DEPTH entries.
//   empty     out : FIFO holds no entries.
//   level     out : occupancy, 0..DEPTH.
//   tx_start  out : one-cycle launch pulse to the transmitter.
//   tx_data   out : byte to the transmitter; held for the whole frame.
//   tx_status in  : transmitter status; 1 = busy, 0 = ready.
//   overflow  out : sticky dropped-write flag (see macro above).
//
// Every output comes from a register or is decoded from registers only.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int FRAME_BITS   = 8,
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [FRAME_BITS-1:0]   wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    tx_start,
  output logic [FRAME_BITS-1:0]   tx_data,
  input  logic                    tx_status,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [FRAME_BITS-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the
  // low index bits coincide.
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  r_tx_start;
  logic [FRAME_BITS-1:0] r_tx_data;
  logic [CW-1:0]         r_cnt;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // Full is judged on the pre-edge state, so a write into a full FIFO is
  // dropped even when a pop happens in the same cycle.
  assign w_push  = wr_en && !w_full;
  // The only pop is the IDLE launch; tx_status low gates it so that a
  // transmitter still busy (e.g. after our own reset) never gets a start.
  assign w_pop   = (r_state == S_IDLE) && !w_empty && !tx_status;

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_next_state = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_next_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_status) begin
          w_next_state = S_WAIT_DONE;
        end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never picked the byte up; it is abandoned.
          w_next_state = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_status) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FIFO pointers; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage carries data only and is not reset; stale contents are
  // unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Launch register: tx_data only changes in the launch cycle, so it stays
  // stable across the transmitter's latch edge and the whole frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_start <= w_pop;
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

  // Busy-wait timeout counter, cleared on the way into WAIT_BUSY.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state == S_LAUNCH) begin
      r_cnt <= '0;
    end else if ((r_state == S_WAIT_BUSY) && !tx_status) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_overflow;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (wr_en && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_wr_ptr - r_rd_ptr;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo. Every byte expected on the transmitter
// side is queued when it is written; an independent monitor pops that queue
// on each tx_start pulse and compares tx_data. A small transmitter model
// answers start pulses with a programmable busy period.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_status;
  logic       overflow;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .FRAME_BITS  (8),
    .DEPTH       (16),
    .BUSY_TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_status(tx_status),
    .overflow (overflow)
  );

  int         tests    = 0;
  int         fails    = 0;
  int         launches = 0;
  logic [7:0] sb[$];

`ifdef UART_TX_FIFO_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  // Transmitter model: busy for busy_len cycles after it sees a start pulse.
  logic model_en   = 1'b1;
  logic force_busy = 1'b0;
  logic m_busy     = 1'b0;
  int   m_cnt      = 0;
  int   busy_len   = 10;

  assign tx_status = m_busy | force_busy;

  always @(posedge clk) begin
    if (tx_start === 1'b1 && model_en) begin
      m_busy <= 1'b1;
      m_cnt  <= busy_len;
    end else if (m_busy) begin
      if (m_cnt <= 1) m_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each launch must be a single-cycle pulse carrying the next
  // expected byte.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (reset_n === 1'b1 && tx_start === 1'b1) begin
      launches++;
      check("start_single_cycle", {31'd0, prev_start}, 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_launch: got tx_data 0x%0h, expected no launch", tx_data);
      end else begin
        check("launch_data", {24'd0, tx_data}, {24'd0, sb.pop_front()});
      end
    end
    prev_start <= (tx_start === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b, input bit expect_launch);
    wr_en   = 1'b1;
    wr_data = b;
    if (expect_launch) sb.push_back(b);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_launches(input int target, input int bound, input string name);
    int k = 0;
    while (launches < target && k < bound) begin
      cyc(1);
      k++;
    end
    check(name, {31'd0, (launches >= target)}, 32'd1);
  endtask

  initial begin
    int base;
    int gap;

    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;

    // Reset state
    cyc(2);
    check("rst_empty",    {31'd0, empty},    32'd1);
    check("rst_full",     {31'd0, full},     32'd0);
    check("rst_level",    {27'd0, level},    32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data",  {24'd0, tx_data},  32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    cyc(1);

    // Single byte, transmitter idle
    busy_len = 10;
    push(8'hA5, 1'b1);
    check("wr_level_1",   {27'd0, level},    32'd1);
    check("wr_empty_0",   {31'd0, empty},    32'd0);
    cyc(1);
    check("launch_start", {31'd0, tx_start}, 32'd1);
    check("launch_data0", {24'd0, tx_data},  32'hA5);
    check("pop_level_0",  {27'd0, level},    32'd0);
    cyc(1);
    check("start_low",    {31'd0, tx_start}, 32'd0);
    cyc(5);
    check("data_held",    {24'd0, tx_data},  32'hA5);
    cyc(20);

    // Three bytes back to back, long frames
    busy_len = 160;
    base = launches;
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    push(8'h03, 1'b1);
    wait_launches(base + 3, 1000, "three_launch_timeout");
    cyc(200);
    check("three_launches", launches, base + 3);

    // Fill to full with the transmitter held busy, then overflow
    force_busy = 1'b1;
    busy_len   = 5;
    base       = launches;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'b1);
    check("fill_full",   {31'd0, full},  32'd1);
    check("fill_level",  {27'd0, level}, 32'd16);
    check("fill_empty",  {31'd0, empty}, 32'd0);
    push(8'hFF, 1'b0);
    check("ovf_full",    {31'd0, full},     32'd1);
    check("ovf_level",   {27'd0, level},    32'd16);
    check("ovf_flag",    {31'd0, overflow}, {31'd0, EXP_OVF});
    force_busy = 1'b0;
    wait_launches(base + 16, 2000, "drain_timeout");
    cyc(30);
    check("drain_empty", {31'd0, empty},    32'd1);
    check("drain_level", {27'd0, level},    32'd0);
    check("ovf_sticky",  {31'd0, overflow}, {31'd0, EXP_OVF});
    check("drain_count", launches, base + 16);

    // Transmitter never goes busy: timeout then next byte
    model_en = 1'b0;
    base     = launches;
    push(8'h55, 1'b1);
    push(8'h66, 1'b1);
    check("to_first_start", {31'd0, tx_start}, 32'd1);
    check("to_first_data",  {24'd0, tx_data},  32'h55);
    gap = 0;
    do begin
      cyc(1);
      gap++;
    end while (tx_start !== 1'b1 && gap < 20);
    check("timeout_gap",    gap, 6);
    cyc(15);
    check("timeout_count",  launches, base + 2);
    check("timeout_empty",  {31'd0, empty}, 32'd1);

    // Reset mid-frame with bytes queued
    model_en = 1'b1;
    busy_len = 160;
    push(8'h81, 1'b1);
    for (int i = 2; i <= 6; i++) push(8'h80 + 8'(i), 1'b0);
    cyc(10);
    check("queued_level",   {27'd0, level},    32'd5);
    reset_n = 1'b0;
    cyc(1);
    check("mid_rst_level",  {27'd0, level},    32'd0);
    check("mid_rst_empty",  {31'd0, empty},    32'd1);
    check("mid_rst_start",  {31'd0, tx_start}, 32'd0);
    check("mid_rst_ovf",    {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    base = launches;
    cyc(300);
    check("no_launch_after_rst", launches, base);
    push(8'h99, 1'b1);
    wait_launches(base + 1, 50, "post_rst_launch_timeout");
    cyc(200);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
